// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//   OAM DMA controller behind CPU register $4014. A CPU write of page P stalls
//   the CPU through RDY, then masters the bus to copy $P00-$PFF into sprite
//   memory. Each byte is one bus read of the source address followed by one
//   bus write to the PPU OAMDATA register.
//
//   All registers update on the falling edge of i_clk.
//
// Ports
//   i_clk          system clock (falling-edge active)
//   i_reset        asynchronous, active-high reset
//   i_cs_n         chip select, low when the CPU addresses $4014
//   i_rw           CPU read/~write (0 = write)
//   i_data         CPU data bus, page number on a $4014 write
//   i_bus_data     bus read data during DMA READ cycles
//   o_rdy          CPU RDY, 0 halts the CPU
//   o_dma_active   1 while this block owns the bus (READ and WRITE)
//   o_bus_address  DMA bus address
//   o_bus_rw       DMA bus read/~write
//   o_bus_data     DMA write data, 0 outside WRITE
// -----------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs_n,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    input  logic [7:0]  i_bus_data,
    output logic        o_rdy,
    output logic        o_dma_active,
    output logic [15:0] o_bus_address,
    output logic        o_bus_rw,
    output logic [7:0]  o_bus_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_index;
    logic [7:0]  r_byte;
    logic        r_parity;

    // r_byte is only non-zero while in WRITE, so it drives the write data
    // directly and the bus sees 0 in every other state.
    assign o_bus_data = r_byte;

    // Outputs are registered with the value the next state decodes to, so they
    // change on the same edge as the state and clear asynchronously on reset.
    // NOTE: every register here is assigned with <= so all updates in this
    // block see the pre-edge values (e.g. WRITE tests the old r_index).
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_page        <= 8'h00;
            r_index       <= 8'h00;
            r_byte        <= 8'h00;
            r_parity      <= 1'b0;
            o_rdy         <= 1'b1;
            o_dma_active  <= 1'b0;
            o_bus_address <= 16'h0000;
            o_bus_rw      <= 1'b1;
        end else begin
            r_parity <= ~r_parity;

            case (r_state)
                S_IDLE: begin
                    // Only a CPU write to $4014 starts a transfer.
                    if (!i_cs_n && !i_rw) begin
                        r_page  <= i_data;
                        r_index <= 8'h00;
                        r_state <= S_HALT;
                        o_rdy   <= 1'b0;
                    end
                end

                S_HALT: begin
                    // An odd cycle here needs one extra dummy cycle so the
                    // read/write pairs land on the bus-aligned phase.
                    if (r_parity) begin
                        r_state <= S_ALIGN;
                    end else begin
                        r_state       <= S_READ;
                        o_dma_active  <= 1'b1;
                        o_bus_address <= {r_page, r_index};
                        o_bus_rw      <= 1'b1;
                    end
                end

                S_ALIGN: begin
                    r_state       <= S_READ;
                    o_dma_active  <= 1'b1;
                    o_bus_address <= {r_page, r_index};
                    o_bus_rw      <= 1'b1;
                end

                S_READ: begin
                    r_byte        <= i_bus_data;
                    r_state       <= S_WRITE;
                    o_bus_address <= OAMDATA_ADDR;
                    o_bus_rw      <= 1'b0;
                end

                S_WRITE: begin
                    r_index <= r_index + 8'd1;
                    r_byte  <= 8'h00;
                    if (r_index == 8'hFF) begin
                        // Last byte done: release the bus and the CPU.
                        r_state       <= S_IDLE;
                        o_rdy         <= 1'b1;
                        o_dma_active  <= 1'b0;
                        o_bus_address <= 16'h0000;
                        o_bus_rw      <= 1'b1;
                    end else begin
                        // Source stays within the page: the high byte is
                        // always r_page, never a carry out of r_index.
                        r_state       <= S_READ;
                        o_bus_address <= {r_page, r_index + 8'd1};
                        o_bus_rw      <= 1'b1;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    o_rdy         <= 1'b1;
                    o_dma_active  <= 1'b0;
                    o_bus_address <= 16'h0000;
                    o_bus_rw      <= 1'b1;
                    r_byte        <= 8'h00;
                end
            endcase
        end
    end

endmodule
